// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off events onto NUM_VOICES oscillator slots with
// retrigger, free-voice allocation and oldest-voice stealing (1-cycle off gap on reuse).
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_W     = 7,
  parameter int RATE_W     = 24
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         evt_valid_in,
  output logic                         evt_ready_out,
  input  logic                         evt_on_in,
  input  logic [NOTE_W-1:0]            evt_note_in,
  input  logic [RATE_W-1:0]            evt_rate_in,
  input  logic                         all_off_in,
  output logic [NUM_VOICES-1:0]        voice_on_out,
  output logic [NUM_VOICES*RATE_W-1:0] voice_rate_out,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note_out,
  output logic                         steal_out,
  output logic [1:0]                   dbg_state_out
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam logic [VW-1:0] AGE_MAX = VW'(NUM_VOICES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_APPLY  = 2'd2;
  localparam logic [1:0] S_RETRIG = 2'd3;

  localparam logic [2:0] K_FREE   = 3'd0;
  localparam logic [2:0] K_RETRIG = 3'd1;
  localparam logic [2:0] K_STEAL  = 3'd2;
  localparam logic [2:0] K_OFF    = 3'd3;
  localparam logic [2:0] K_DROP   = 3'd4;

  logic [1:0]                           state_q, state_d;
  logic                                 rdy_en_q, rdy_en_d;
  logic                                 evt_on_q, evt_on_d;
  logic [NOTE_W-1:0]                    evt_note_q, evt_note_d;
  logic [RATE_W-1:0]                    evt_rate_q, evt_rate_d;
  logic [VW-1:0]                        tgt_q, tgt_d;
  logic [2:0]                           kind_q, kind_d;
  logic [NUM_VOICES-1:0]                on_q, on_d;
  logic [NUM_VOICES-1:0][RATE_W-1:0]    rate_q, rate_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]    note_q, note_d;
  logic [NUM_VOICES-1:0][VW-1:0]        age_q, age_d;
  logic                                 steal_q, steal_d;

  logic          hit_found, free_found;
  logic [VW-1:0] hit_idx, free_idx, old_idx, tgt_s;
  logic [VW-1:0] old_age;
  logic [2:0]    kind_s;

  // Handshake: an event transfers on a rising edge where evt_valid_in and evt_ready_out are
  // both high; ready is high only in IDLE, after the first post-reset edge, with no panic.
  assign evt_ready_out  = rdy_en_q && (state_q == S_IDLE) && !all_off_in;
  assign voice_on_out   = on_q;
  assign voice_rate_out = rate_q;
  assign voice_note_out = note_q;
  assign steal_out      = steal_q;
  assign dbg_state_out  = state_q;

  // Downward scans leave the lowest matching index; the upward age scan keeps the first maximum.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (on_q[v] && (note_q[v] == evt_note_q)) begin
        hit_found = 1'b1;
        hit_idx   = VW'(v);
      end
      if (!on_q[v]) begin
        free_found = 1'b1;
        free_idx   = VW'(v);
      end
    end
    old_idx = '0;
    old_age = age_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > old_age) begin
        old_age = age_q[v];
        old_idx = VW'(v);
      end
    end
    if (evt_on_q) begin
      if (hit_found) begin
        kind_s = K_RETRIG;
        tgt_s  = hit_idx;
      end else if (free_found) begin
        kind_s = K_FREE;
        tgt_s  = free_idx;
      end else begin
        kind_s = K_STEAL;
        tgt_s  = old_idx;
      end
    end else begin
      kind_s = hit_found ? K_OFF : K_DROP;
      tgt_s  = hit_idx;
    end
  end

  always_comb begin
    state_d    = state_q;
    rdy_en_d   = 1'b1;
    evt_on_d   = evt_on_q;
    evt_note_d = evt_note_q;
    evt_rate_d = evt_rate_q;
    tgt_d      = tgt_q;
    kind_d     = kind_q;
    on_d       = on_q;
    rate_d     = rate_q;
    note_d     = note_q;
    age_d      = age_q;
    steal_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (evt_valid_in && evt_ready_out) begin
          evt_on_d   = evt_on_in;
          evt_note_d = evt_note_in;
          evt_rate_d = evt_rate_in;
          state_d    = S_SEARCH;
        end
      end
      S_SEARCH: begin
        tgt_d   = tgt_s;
        kind_d  = kind_s;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        state_d = S_IDLE;
        if (kind_q == K_FREE || kind_q == K_RETRIG || kind_q == K_STEAL) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (VW'(v) != tgt_q && on_q[v] && age_q[v] != AGE_MAX) age_d[v] = age_q[v] + 1'b1;
          end
          on_d[tgt_q]   = (kind_q == K_FREE);
          rate_d[tgt_q] = evt_rate_q;
          note_d[tgt_q] = evt_note_q;
          age_d[tgt_q]  = '0;
          steal_d       = (kind_q == K_STEAL);
          if (kind_q != K_FREE) state_d = S_RETRIG;
        end else if (kind_q == K_OFF) begin
          on_d[tgt_q]  = 1'b0;
          age_d[tgt_q] = '0;
        end
      end
      S_RETRIG: begin
        on_d[tgt_q] = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Panic wins over any in-flight event; rate/note are kept so a later event sees them intact.
    if (all_off_in) begin
      on_d    = '0;
      age_d   = '0;
      steal_d = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      evt_on_q   <= 1'b0;
      evt_note_q <= '0;
      evt_rate_q <= '0;
      tgt_q      <= '0;
      kind_q     <= K_DROP;
      on_q       <= '0;
      rate_q     <= '0;
      note_q     <= '0;
      age_q      <= '0;
      steal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= rdy_en_d;
      evt_on_q   <= evt_on_d;
      evt_note_q <= evt_note_d;
      evt_rate_q <= evt_rate_d;
      tgt_q      <= tgt_d;
      kind_q     <= kind_d;
      on_q       <= on_d;
      rate_q     <= rate_d;
      note_q     <= note_d;
      age_q      <= age_d;
      steal_q    <= steal_d;
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: event table with hand-computed targets, plus panic and
// mid-retrigger reset sequences.
module tb_voice_allocator;
  localparam int KF = 0, KR = 1, KS = 2, KO = 3, KD = 4;

  typedef struct {
    logic        on;
    logic [6:0]  note;
    logic [23:0] rate;
    int          tgt;
    int          kind;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         evt_valid, evt_ready, evt_on, all_off, steal;
  logic [6:0]   evt_note;
  logic [23:0]  evt_rate;
  logic [7:0]   voice_on;
  logic [191:0] voice_rate;
  logic [55:0]  voice_note;
  logic [1:0]   dbg_state;

  logic [7:0]        m_on;
  logic [7:0][23:0]  m_rate;
  logic [7:0][6:0]   m_note;
  logic [7:0]        exp_q[$];
  vec_t              vecs[16];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                last_tx = -1;
  int                exp_gap = 3;

  voice_allocator dut (
    .clk_in(clk), .rst_n_in(rst_n), .evt_valid_in(evt_valid), .evt_ready_out(evt_ready),
    .evt_on_in(evt_on), .evt_note_in(evt_note), .evt_rate_in(evt_rate), .all_off_in(all_off),
    .voice_on_out(voice_on), .voice_rate_out(voice_rate), .voice_note_out(voice_note),
    .steal_out(steal), .dbg_state_out(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_on(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 256'(voice_on), 256'(m_on));
    end else begin
      e = exp_q.pop_front();
      check(name, 256'(voice_on), 256'(e));
    end
  endtask

  // Drives one event with valid held, then follows it edge by edge against the model.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int tx;
    logic [7:0] after;
    evt_valid = 1'b1;
    evt_on    = v.on;
    evt_note  = v.note;
    evt_rate  = v.rate;
    n = 0;
    while (!evt_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!evt_ready) begin
      check({tag, "_ready_timeout"}, 256'(evt_ready), 256'(1));
      evt_valid = 1'b0;
      return;
    end
    after = m_on;
    if (v.kind == KF) after[v.tgt] = 1'b1;
    if (v.kind == KR || v.kind == KS || v.kind == KO) after[v.tgt] = 1'b0;
    exp_q.push_back(m_on);
    exp_q.push_back(m_on);
    exp_q.push_back(after);
    if (v.kind == KR || v.kind == KS) begin
      after[v.tgt] = 1'b1;
      exp_q.push_back(after);
    end
    @(posedge clk);
    @(negedge clk);
    tx = cyc;
    if (last_tx >= 0) check({tag, "_tx_interval"}, 256'(tx - last_tx), 256'(exp_gap));
    last_tx = tx;
    exp_gap = (v.kind == KR || v.kind == KS) ? 4 : 3;
    check({tag, "_search_ready"}, 256'(evt_ready), 256'(0));
    check({tag, "_search_state"}, 256'(dbg_state), 256'(1));
    check_on({tag, "_search_on"});
    @(negedge clk);
    check({tag, "_apply_ready"}, 256'(evt_ready), 256'(0));
    check_on({tag, "_apply_on"});
    if (v.kind != KD && v.kind != KO) begin
      m_rate[v.tgt] = v.rate;
      m_note[v.tgt] = v.note;
    end
    if (v.kind != KD) m_on[v.tgt] = (v.kind == KF);
    @(negedge clk);
    check_on({tag, "_e2_on"});
    check({tag, "_e2_rate"}, 256'(voice_rate), 256'(m_rate));
    check({tag, "_e2_note"}, 256'(voice_note), 256'(m_note));
    check({tag, "_e2_steal"}, 256'(steal), 256'(v.kind == KS));
    if (v.kind == KR || v.kind == KS) begin
      m_on[v.tgt] = 1'b1;
      check({tag, "_e2_ready"}, 256'(evt_ready), 256'(0));
      @(negedge clk);
      check_on({tag, "_e3_on"});
      check({tag, "_e3_steal"}, 256'(steal), 256'(0));
    end
    check({tag, "_idle_ready"}, 256'(evt_ready), 256'(1));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 7'd60, 24'd1000, 0, KF};
    vecs[1]  = '{1'b1, 7'd61, 24'd1001, 1, KF};
    vecs[2]  = '{1'b1, 7'd62, 24'd1002, 2, KF};
    vecs[3]  = '{1'b1, 7'd63, 24'd1003, 3, KF};
    vecs[4]  = '{1'b1, 7'd64, 24'd1004, 4, KF};
    vecs[5]  = '{1'b1, 7'd65, 24'd1005, 5, KF};
    vecs[6]  = '{1'b1, 7'd66, 24'd1006, 6, KF};
    vecs[7]  = '{1'b1, 7'd67, 24'd1007, 7, KF};
    vecs[8]  = '{1'b1, 7'd70, 24'd2000, 0, KS};
    vecs[9]  = '{1'b1, 7'd62, 24'd500,  2, KR};
    vecs[10] = '{1'b0, 7'd61, 24'd9,    1, KO};
    vecs[11] = '{1'b0, 7'd99, 24'd9,    0, KD};
    vecs[12] = '{1'b1, 7'd80, 24'd3000, 1, KF};
    vecs[13] = '{1'b1, 7'd81, 24'd3100, 3, KS};
    vecs[14] = '{1'b1, 7'd81, 24'd3200, 3, KR};
    vecs[15] = '{1'b0, 7'd70, 24'd9,    0, KO};

    m_on = '0; m_rate = '0; m_note = '0;
    rst_n = 1'b0; evt_valid = 1'b0; evt_on = 1'b0; evt_note = '0; evt_rate = '0; all_off = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_on", 256'(voice_on), 256'(0));
    check("reset_rate", 256'(voice_rate), 256'(0));
    check("reset_note", 256'(voice_note), 256'(0));
    check("reset_steal", 256'(steal), 256'(0));
    check("reset_ready", 256'(evt_ready), 256'(0));
    check("reset_state", 256'(dbg_state), 256'(0));
    rst_n = 1'b1;
    #2;
    check("release_ready_before_edge", 256'(evt_ready), 256'(0));
    @(negedge clk);
    check("release_ready_first_cycle", 256'(evt_ready), 256'(1));

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    evt_valid = 1'b0;

    // Panic during SEARCH of a note-on.
    @(negedge clk);
    evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd90; evt_rate = 24'd4444;
    @(posedge clk);
    @(negedge clk);
    evt_valid = 1'b0;
    check("panic_in_search", 256'(dbg_state), 256'(1));
    all_off = 1'b1;
    #1;
    check("panic_ready_low", 256'(evt_ready), 256'(0));
    @(negedge clk);
    m_on = '0;
    check("panic_on", 256'(voice_on), 256'(0));
    check("panic_state", 256'(dbg_state), 256'(0));
    check("panic_note_kept", 256'(voice_note), 256'(m_note));
    check("panic_rate_kept", 256'(voice_rate), 256'(m_rate));
    check("panic_ready_held", 256'(evt_ready), 256'(0));
    all_off = 1'b0;
    #1;
    check("panic_ready_back", 256'(evt_ready), 256'(1));
    repeat (3) @(negedge clk);
    check("panic_aborted_on", 256'(voice_on), 256'(0));
    check("panic_aborted_note", 256'(voice_note), 256'(m_note));
    last_tx = -1;
    run_vec('{1'b1, 7'd90, 24'd4444, 0, KF}, "post_panic");
    evt_valid = 1'b0;

    // Reset asserted while a retrigger sits in RETRIG.
    @(negedge clk);
    evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd90; evt_rate = 24'd777;
    @(posedge clk);
    @(negedge clk);
    evt_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("retrig_state", 256'(dbg_state), 256'(3));
    check("retrig_gap_on", 256'(voice_on), 256'(0));
    rst_n = 1'b0;
    #1;
    check("midrst_on", 256'(voice_on), 256'(0));
    check("midrst_rate", 256'(voice_rate), 256'(0));
    check("midrst_note", 256'(voice_note), 256'(0));
    check("midrst_state", 256'(dbg_state), 256'(0));
    check("midrst_ready", 256'(evt_ready), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", 256'(evt_ready), 256'(1));
    check("midrst_aborted_on", 256'(voice_on), 256'(0));
    m_on = '0; m_rate = '0; m_note = '0;
    last_tx = -1;
    run_vec('{1'b1, 7'd55, 24'd1234, 0, KF}, "post_reset");
    evt_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
